// File: rtl/qedmma_pkg.sv
// qedmma_pkg: shared fixed-point types (Q16.16 fp_t), accumulator guard bits, fp_t limits and the transpose-MAC FSM state type
package qedmma_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS = 16;
  localparam int STATE_DIM = 4;
  localparam int ACC_GUARD_BITS = $clog2(STATE_DIM);
  typedef logic signed [DATA_WIDTH-1:0] fp_t;
  localparam fp_t FP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam fp_t FP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MAC, FLUSH, DONE} mtvm_state_t;
endpackage

// File: rtl/fp_round_sat.sv
// fp_round_sat: round-half-up a wide signed accumulator to fp_t, clamp (SATURATE=1) or wrap; ports acc in, q fp_t out, sat out-of-range flag
module fp_round_sat
  import qedmma_pkg::*;
#(
  parameter int ACC_W = 2*DATA_WIDTH + ACC_GUARD_BITS,
  parameter bit SATURATE = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output fp_t                     q,
  output logic                    sat
);
  localparam int SW = ACC_W + 1 - FRAC_BITS;
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_BITS-1);
  localparam logic signed [SW-1:0] MAX_W = SW'(FP_MAX);
  localparam logic signed [SW-1:0] MIN_W = SW'(FP_MIN);
  logic signed [ACC_W:0] rnd;
  logic signed [SW-1:0] shr;
  logic hi, lo;
  always_comb begin
    rnd = $signed({acc[ACC_W-1], acc}) + HALF;
    shr = SW'(rnd >>> FRAC_BITS);
    hi = shr > MAX_W;
    lo = shr < MIN_W;
    sat = hi | lo;
    q = (SATURATE && hi) ? FP_MAX : (SATURATE && lo) ? FP_MIN : fp_t'(shr[DATA_WIDTH-1:0]);
  end
endmodule

// File: rtl/matrix_transpose_vector_mult.sv
// matrix_transpose_vector_mult: y = M^T x on one shared MAC; ports clk, rst_n, start, M[row][col], x in; y, busy, done pulse, sticky overflow out
module matrix_transpose_vector_mult
  import qedmma_pkg::*;
#(
  parameter int DIM = STATE_DIM,
  parameter bit SATURATE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  fp_t  M [DIM][DIM],
  input  fp_t  x [DIM],
  output fp_t  y [DIM],
  output logic busy,
  output logic done,
  output logic overflow
);
  localparam int IW = DIM > 1 ? $clog2(DIM) : 1;
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(DIM);
  localparam int PW = 2*DATA_WIDTH;
  mtvm_state_t state, state_nx;
  fp_t m_q [DIM][DIM];
  fp_t x_q [DIM];
  fp_t buf_q [DIM];
  logic [IW-1:0] r_idx, c_idx, p_col;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic p_vld, p_first, p_last, ovf_q, accept, last_mac, col_sat;
  fp_t col_q;
  assign accept = (state == IDLE) && start;
  assign last_mac = (state == MAC) && (r_idx == IW'(DIM-1)) && (c_idx == IW'(DIM-1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE)  ? (start ? MAC : IDLE) :
               (state == MAC)   ? (last_mac ? FLUSH : MAC) :
               (state == FLUSH) ? DONE : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (state == MAC) prod <= PW'(m_q[r_idx][c_idx]) * PW'(x_q[r_idx]);
  end
  assign acc_sum = (p_first ? '0 : acc) + ACC_W'(prod);
  fp_round_sat #(.ACC_W(ACC_W), .SATURATE(SATURATE)) u_round_sat (
    .acc(acc_sum),
    .q  (col_q),
    .sat(col_sat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) begin
        x_q[i] <= '0;
        buf_q[i] <= '0;
        y[i] <= '0;
        for (int j = 0; j < DIM; j++) m_q[i][j] <= '0;
      end
      r_idx <= '0;
      c_idx <= '0;
      p_col <= '0;
      p_vld <= 1'b0;
      p_first <= 1'b0;
      p_last <= 1'b0;
      acc <= '0;
      ovf_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      p_vld <= state == MAC;
      p_first <= r_idx == '0;
      p_last <= r_idx == IW'(DIM-1);
      p_col <= c_idx;
      if (accept) begin
        m_q <= M;
        x_q <= x;
        r_idx <= '0;
        c_idx <= '0;
        acc <= '0;
        ovf_q <= 1'b0;
        overflow <= 1'b0;
      end else if (state == MAC) begin
        r_idx <= (r_idx == IW'(DIM-1)) ? '0 : r_idx + 1'b1;
        if (r_idx == IW'(DIM-1)) c_idx <= c_idx + 1'b1;
      end
      if (p_vld) begin
        acc <= acc_sum;
        if (p_last) begin
          buf_q[p_col] <= col_q;
          ovf_q <= ovf_q | col_sat;
        end
      end
      if (state == FLUSH) begin
        for (int c = 0; c < DIM; c++) y[c] <= (IW'(c) == p_col) ? col_q : buf_q[c];
        overflow <= ovf_q | col_sat;
      end
    end
  end
endmodule

// File: tb/tb_matrix_transpose_vector_mult.sv
// tb_matrix_transpose_vector_mult: directed checks of y = M^T x, timing, rounding, saturation/wrap, handshake and reset
module tb_matrix_transpose_vector_mult;
  import qedmma_pkg::*;
  localparam int D = STATE_DIM;
  localparam fp_t ONE = 32'h0001_0000;
  localparam fp_t TWO = 32'h0002_0000;
  localparam fp_t NEG3 = 32'hFFFD_0000;
  localparam fp_t HALF = 32'h0000_8000;
  localparam fp_t K30 = 32'h7530_0000;
  localparam fp_t NK30 = 32'h8AD0_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  fp_t M [D][D];
  fp_t x [D];
  fp_t y [D];
  fp_t yw [D];
  logic busy, done, overflow, busy_w, done_w, ovf_w;
  int checks = 0;
  int errors = 0;
  int dcyc, bcyc, nd, d1, d2;
  matrix_transpose_vector_mult #(.DIM(D), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(M), .x(x),
    .y(y), .busy(busy), .done(done), .overflow(overflow)
  );
  matrix_transpose_vector_mult #(.DIM(D), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .M(M), .x(x),
    .y(yw), .busy(busy_w), .done(done_w), .overflow(ovf_w)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_y(input string tag, input fp_t e [D]);
    for (int i = 0; i < D; i++) chk($sformatf("%s_y%0d", tag, i), y[i], e[i]);
  endtask
  task automatic zero_ops();
    for (int r = 0; r < D; r++) begin
      x[r] = '0;
      for (int c = 0; c < D; c++) M[r][c] = '0;
    end
  endtask
  task automatic load_identity();
    zero_ops();
    for (int r = 0; r < D; r++) M[r][r] = ONE;
    x[0] = ONE; x[1] = TWO; x[2] = NEG3; x[3] = HALF;
  endtask
  task automatic run_op(output int dc, output int bc, output int n);
    dc = 0; bc = 0; n = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (busy) bc++;
      if (done) begin
        n++;
        if (dc == 0) dc = k;
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    zero_ops();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) chk($sformatf("rst_y%0d", i), y[i], 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_identity();
    run_op(dcyc, bcyc, nd);
    chk("id_done_cyc", dcyc, 18);
    chk("id_busy_cyc", bcyc, 18);
    chk("id_ndone", nd, 1);
    chk("id_ovf", 32'(overflow), 32'd0);
    chk_y("id", '{ONE, TWO, NEG3, HALF});
    zero_ops();
    M[0][1] = ONE;
    x[0] = TWO;
    run_op(dcyc, bcyc, nd);
    chk_y("tr", '{32'd0, TWO, 32'd0, 32'd0});
    zero_ops();
    for (int r = 0; r < D; r++) begin
      M[r][0] = K30;
      x[r] = K30;
    end
    run_op(dcyc, bcyc, nd);
    chk("satp_y0", y[0], 32'h7FFF_FFFF);
    chk("satp_ovf", 32'(overflow), 32'd1);
    chk("satp_y1", y[1], 32'd0);
    chk("wrapp_y0", yw[0], 32'hA400_0000);
    chk("wrapp_ovf", 32'(ovf_w), 32'd1);
    for (int r = 0; r < D; r++) x[r] = NK30;
    run_op(dcyc, bcyc, nd);
    chk("satn_y0", y[0], 32'h8000_0000);
    chk("satn_ovf", 32'(overflow), 32'd1);
    chk("wrapn_y0", yw[0], 32'h5C00_0000);
    zero_ops();
    M[0][0] = 32'h0000_0001;
    x[0] = 32'h0000_8000;
    run_op(dcyc, bcyc, nd);
    chk("rnd_up_y0", y[0], 32'h0000_0001);
    chk("rnd_up_ovf", 32'(overflow), 32'd0);
    x[0] = 32'hFFFF_8000;
    run_op(dcyc, bcyc, nd);
    chk("rnd_neg_y0", y[0], 32'h0000_0000);
    nd = 0;
    for (int c = 0; c <= 40; c++) begin
      for (int r = 0; r < D; r++) begin
        x[r] = (c == 3) ? ((r == 1) ? TWO : ONE) : fp_t'(c << 16);
        for (int k = 0; k < D; k++) M[r][k] = (c == 3) ? ONE : 32'h0003_0000 + c;
      end
      start = (c == 3) || (c == 17);
      @(posedge clk); #1;
      if (done) nd++;
    end
    start = 1'b0;
    chk("hs_ndone", nd, 1);
    chk_y("hs", '{32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 32'h0005_0000});
    zero_ops();
    for (int r = 0; r < D; r++) begin
      M[r][0] = K30;
      x[r] = K30;
    end
    d1 = 0; d2 = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) load_identity();
      if (k == 20) start = 1'b0;
      if (done) begin
        if (d1 == 0) d1 = k;
        else d2 = k;
      end
      if (k == 18) chk("hold_ovf_set", 32'(overflow), 32'd1);
      if (k == 19) chk("hold_idle_busy", 32'(busy), 32'd0);
      if (k == 20) begin
        chk("hold_busy2", 32'(busy), 32'd1);
        chk("hold_ovf_clr", 32'(overflow), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk("hold_done1", d1, 18);
    chk("hold_done2", d2, 37);
    chk_y("hold", '{ONE, TWO, NEG3, HALF});
    zero_ops();
    M[1][1] = TWO;
    x[1] = TWO;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < D; i++) chk($sformatf("abort_y%0d", i), y[i], 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    nd = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("abort_nodone", nd, 0);
    load_identity();
    run_op(dcyc, bcyc, nd);
    chk("post_done_cyc", dcyc, 18);
    chk("post_busy_cyc", bcyc, 18);
    chk("post_ndone", nd, 1);
    chk("post_ovf", 32'(overflow), 32'd0);
    chk_y("post", '{ONE, TWO, NEG3, HALF});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_transpose_vector_mult.md
MATRIX_TRANSPOSE_VECTOR_MULT -- requirements
Module: matrix_transpose_vector_mult

Interface
REQ-001 SHALL have parameter DIM, default qedmma_pkg STATE_DIM, square matrix dimension and vector length.
REQ-002 SHALL have parameter SATURATE, default 1; 1 = clamp out-of-range results, 0 = wrap (truncate).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port M  input  fp_t [DIM][DIM]  matrix, M[row][col].
REQ-007 SHALL have port x  input  fp_t [DIM]  operand vector.
REQ-008 SHALL have port y  output  fp_t [DIM]  result y = M^T x.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when y is valid.
REQ-011 SHALL have port overflow  output  1  sticky; a column saturated or wrapped in the last operation.

Function
REQ-012 SHALL compute y[c] = sum over r of M[r][c]*x[r], with one multiply-accumulate per cycle on a single shared MAC.
REQ-013 SHALL capture M and x into internal registers on the accepted start edge; later input changes SHALL NOT affect the result.
REQ-014 SHALL use FSM states IDLE, MAC, FLUSH, DONE.
- IDLE->MAC on start.
- MAC runs DIM*DIM cycles, row index inner and column index outer.
- MAC->FLUSH after the last product.
- FLUSH->DONE after one cycle, to drain the product register.
- DONE->IDLE unconditionally.
REQ-015 SHALL register each product, then accumulate it into an accumulator of width 2*DATA_WIDTH+$clog2(DIM) bits, cleared at the start of each column.
REQ-016 SHALL convert each column result to fp_t as follows:
- add 2^(FRAC_BITS-1), i.e. round half-up;
- arithmetic shift right by FRAC_BITS;
- saturate to the fp_t min/max when SATURATE=1, otherwise keep the low DATA_WIDTH bits.
REQ-017 SHALL hold converted results in an internal buffer; y SHALL change only in the DONE cycle, with all DIM elements updated together.
REQ-018 SHALL assert done for exactly one cycle (state DONE), DIM*DIM+2 cycles after the start-sampling edge; this is 18 cycles for DIM=4.
REQ-019 SHALL drive busy high from the cycle after the accepted start through the DONE cycle inclusive.
REQ-020 SHALL ignore start in MAC, FLUSH and DONE; a start held high SHALL be accepted in the IDLE cycle following DONE.
REQ-021 SHALL set overflow with done if any column exceeded the fp_t range; overflow SHALL hold until the next accepted start clears it.
REQ-022 SHALL hold y stable between done pulses.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-operation, immediately clear y, busy, done, overflow, the accumulator, the counters and the captured operands, and enter IDLE.
REQ-024 SHALL NOT pulse done for an operation aborted by reset; the first start after reset release SHALL run normally.

Structure
REQ-025 SHALL take fp_t, DATA_WIDTH, FRAC_BITS and STATE_DIM from qedmma_pkg; ACC_GUARD_BITS and the fp_t min/max constants SHALL be added to qedmma_pkg.
REQ-026 SHALL place rounding and saturation in one sub-module, fp_round_sat (accumulator in; fp_t out; sat flag out), shared with future accumulate blocks.
REQ-027 SHALL infer the product as one DSP multiplier with a registered output.

Verification (qedmma_pkg DATA_WIDTH=32, FRAC_BITS=16, DIM=4)
REQ-028 Identity: M=I, x=[1.0,2.0,-3.0,0.5] -> y=x; done exactly 18 cycles after start; overflow=0; busy high for 18 cycles.
REQ-029 Transpose check: M[0][1]=1.0, all other elements 0, x=[2.0,0,0,0] -> y=[0,2.0,0,0]; a plain M*x would give all zeros.
REQ-030 Saturation: column 0 of M all 30000.0, x all 30000.0 -> y[0]=0x7FFFFFFF and overflow=1; with x negated -> y[0]=0x80000000. With SATURATE=0, y[0] equals the low 32 bits and overflow=1.
REQ-031 Rounding: M[0][0]=0x00000001, x[0]=0x00008000 -> y[0]=0x00000001; with x[0]=0xFFFF8000 -> y[0]=0x00000000.
REQ-032 Handshake: after start, change M and x every cycle and pulse start at cycles 3 and 17 -> result matches the captured operands and exactly one done. Holding start high through DONE -> second operation accepted the next cycle and overflow cleared.
REQ-033 Reset: assert rst_n low at cycle 7 of an operation -> y=0 and busy=0 immediately, no done pulse. A subsequent identity run passes per REQ-028.
